mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_pkg.sv | 31 +++
 rtl/mem_dma.sv | 195 +++++++++++++++++++
 tb/tb_mem_dma.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for mem_dma: register map, CTRL/STATUS bit positions,
// FSM state encoding and the word-address helper.
package mem_dma_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_SRC    = 8'h10;
  localparam logic [7:0] ADDR_DST    = 8'h11;
  localparam logic [7:0] ADDR_LEN    = 8'h12;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Byte address of word idx relative to base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Register-programmed word-copy DMA engine with a valid/ready memory initiator port.
// Optional feature: define DMA_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES cycles.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_e      state_q;
  logic [31:0] src_q, dst_q, buf_q;
  logic [15:0] len_q, idx_q;
  logic        done_q, error_q, abort_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic        busy, reg_wr, ctrl_wr, start_req, abort_req, tmo_hit;
  logic [15:0] idx_d;

  assign busy      = (state_q != ST_IDLE);
  assign reg_wr    = cs & we;
  assign ctrl_wr   = reg_wr & (address == ADDR_CTRL);
  assign abort_req = ctrl_wr & write_data[CTRL_ABORT];
  assign start_req = ctrl_wr & write_data[CTRL_START] & ~write_data[CTRL_ABORT] & ~busy;
  assign idx_d     = idx_q + 16'd1;

  assign ready     = cs;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

`ifdef DMA_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q;

  // Wait counter runs only while a request is outstanding, so every new request starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
    end else if (!mem_valid_q || mem_ready) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit = mem_valid_q & ~mem_ready & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Configuration registers; frozen for the whole transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= 32'd0;
      dst_q <= 32'd0;
      len_q <= 16'd0;
    end else if (reg_wr && !busy) begin
      case (address)
        ADDR_SRC: src_q <= {write_data[31:2], 2'b00};
        ADDR_DST: dst_q <= {write_data[31:2], 2'b00};
        ADDR_LEN: len_q <= write_data[15:0];
        default:  src_q <= src_q;
      endcase
    end
  end

  // Sequencer. A request is raised only from a cycle where mem_valid is low,
  // which guarantees the idle cycle after every completed handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 16'd0;
      buf_q       <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'h0;
    end else begin
      if (abort_req && busy) abort_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (start_req) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= 16'd0;
            if (len_q == 16'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q     <= ST_RD;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= src_q;
              mem_wstrb_q <= 4'h0;
              mem_wdata_q <= 32'd0;
            end
          end
        end
        ST_RD: begin
          if (!mem_valid_q) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= word_addr(src_q, idx_q);
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'd0;
          end else if (mem_ready) begin
            buf_q       <= mem_rdata;
            mem_valid_q <= 1'b0;
            state_q     <= ST_WR;
          end else if (tmo_hit) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_ERR;
          end
        end
        ST_WR: begin
          if (!mem_valid_q) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= word_addr(dst_q, idx_q);
            mem_wstrb_q <= 4'hF;
            mem_wdata_q <= buf_q;
          end else if (mem_ready || tmo_hit) begin
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'd0;
            if (!mem_ready) begin
              state_q <= ST_ERR;
            end else begin
              idx_q <= idx_d;
              if (idx_d == len_q) begin
                state_q <= ST_DONE;
              end else if (abort_q || abort_req) begin
                state_q <= ST_IDLE;
                abort_q <= 1'b0;
              end else begin
                state_q <= ST_RD;
              end
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          error_q <= 1'b1;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_valid_q <= 1'b0;
          mem_wstrb_q <= 4'h0;
          mem_wdata_q <= 32'd0;
        end
      endcase
    end
  end

  // Register read mux; CTRL is write-only and unmapped words read as zero.
  always_comb begin
    read_data = 32'd0;
    case (address)
      ADDR_STATUS: begin
        read_data[STAT_BUSY]  = busy;
        read_data[STAT_DONE]  = done_q;
        read_data[STAT_ERROR] = error_q;
      end
      ADDR_SRC: read_data = src_q;
      ADDR_DST: read_data = dst_q;
      ADDR_LEN: read_data = {16'd0, len_q};
      default:  read_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: randomized memory contents and responder latency, checked
// against a transaction-list model of the word copy built from the register settings.
module tb_mem_dma;

  localparam logic [7:0]  A_CTRL = 8'h08;
  localparam logic [7:0]  A_STAT = 8'h09;
  localparam logic [7:0]  A_SRC  = 8'h10;
  localparam logic [7:0]  A_DST  = 8'h11;
  localparam logic [7:0]  A_LEN  = 8'h12;
  localparam logic [31:0] MEMSEED = 32'h5A5A_1234;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // responder configuration and protocol observations
  int  delay_cfg = 0;
  bit  rand_delay = 1'b0;
  int  cur_delay, wait_cnt;
  bit  have_req = 1'b0;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  int  stab_viol = 0, gap_viol = 0, idle_viol = 0, valid_hi = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr[$], log_data[$];
  logic [3:0]  log_strb[$];
  logic [31:0] exp_addr[$], exp_data[$], exp_src_data[$];
  logic [3:0]  exp_strb[$];
  logic [31:0] exp_dst;
  int          exp_len;

  mem_dma #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ MEMSEED);
  endfunction

  // Memory responder and bus-protocol monitor, acting on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ready = 1'b0;
      have_req  = 1'b0;
    end else if (mem_valid !== 1'b1) begin
      if (mem_wstrb !== 4'h0 || mem_wdata !== 32'd0) idle_viol++;
      if (have_req && mem_ready !== 1'b1) stab_viol++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      have_req  = 1'b0;
    end else begin
      valid_hi++;
      if (mem_ready === 1'b1) begin
        gap_viol++;
        mem_ready = 1'b0;
      end
      if (!have_req) begin
        have_req  = 1'b1;
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
        req_wstrb = mem_wstrb;
        wait_cnt  = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : delay_cfg;
      end else if (mem_addr !== req_addr || mem_wdata !== req_wdata || mem_wstrb !== req_wstrb) begin
        stab_viol++;
      end
      if (cur_delay >= 0 && wait_cnt >= cur_delay) begin
        mem_ready = 1'b1;
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
        log_strb.push_back(mem_wstrb);
        if (mem_wstrb == 4'h0) mem_rdata = mem_rd(mem_addr);
        else begin
          mem[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end
        have_req = 1'b0;
      end else begin
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'd0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0; address = 8'h00;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic [31:0] st;
    int n = 0;
    reg_read(A_STAT, st);
    while (st[0] === 1'b1 && n < budget) begin
      reg_read(A_STAT, st);
      n++;
    end
    check({tag, "_idle"}, {31'd0, st[0]}, 32'd0);
  endtask

  // Fill source words, build the expected read/write sequence, program and start.
  task automatic prep_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] a, v;
    exp_addr.delete(); exp_data.delete(); exp_strb.delete(); exp_src_data.delete();
    log_addr.delete(); log_data.delete(); log_strb.delete();
    exp_dst = dst;
    exp_len = len;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(i * 4);
      mem[a] = $urandom;
    end
    for (int i = 0; i < len; i++) begin
      a = src + 32'(i * 4);
      v = mem_rd(a);
      exp_src_data.push_back(v);
      exp_addr.push_back(a);            exp_strb.push_back(4'h0); exp_data.push_back(32'd0);
      exp_addr.push_back(dst + 32'(i * 4)); exp_strb.push_back(4'hF); exp_data.push_back(v);
    end
    reg_write(A_SRC, src);
    reg_write(A_DST, dst);
    reg_write(A_LEN, 32'(len));
    reg_write(A_CTRL, 32'h0000_0001);
  endtask

  task automatic verify_copy(input string tag);
    logic [31:0] st;
    check({tag, "_txn_count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      check({tag, "_addr"}, log_addr[i], exp_addr[i]);
      check({tag, "_strb"}, {28'd0, log_strb[i]}, {28'd0, exp_strb[i]});
      check({tag, "_wdata"}, log_data[i], exp_data[i]);
    end
    for (int i = 0; i < exp_len; i++)
      check({tag, "_dst_word"}, mem_rd(exp_dst + 32'(i * 4)), exp_src_data[i]);
    reg_read(A_STAT, st);
    check({tag, "_status"}, st, 32'h0000_0002);
  endtask

  initial begin
    logic [31:0] rd, s, d;
    int n, writes, len;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    reg_read(A_STAT, rd); check("rst_status", rd, 32'd0);
    reg_read(A_SRC, rd);  check("rst_src", rd, 32'd0);
    reg_read(A_DST, rd);  check("rst_dst", rd, 32'd0);
    reg_read(A_LEN, rd);  check("rst_len", rd, 32'd0);

    cs = 1'b1; address = A_STAT;
    #1 check("ready_follows_cs_hi", {31'd0, ready}, 32'd1);
    cs = 1'b0;
    #1 check("ready_follows_cs_lo", {31'd0, ready}, 32'd0);
    @(negedge clk);

    reg_write(A_SRC, 32'h4000_0003); reg_read(A_SRC, rd); check("src_align", rd, 32'h4000_0000);
    reg_write(A_DST, 32'h1234_5677); reg_read(A_DST, rd); check("dst_align", rd, 32'h1234_5674);
    reg_write(A_LEN, 32'hABCD_1234); reg_read(A_LEN, rd); check("len_16bit", rd, 32'h0000_1234);
    reg_read(A_CTRL, rd); check("ctrl_reads_zero", rd, 32'd0);
    reg_read(8'h13, rd);  check("unmapped_zero", rd, 32'd0);

    // basic three-word copy, responder ready after one cycle
    delay_cfg = 0; rand_delay = 1'b0;
    prep_copy(32'h4000_0000, 32'h4000_1000, 3);
    wait_idle(500, "basic");
    verify_copy("basic");

    // zero-length transfer: no bus traffic, done two cycles after start
    reg_write(A_LEN, 32'd0);
    valid_hi = 0;
    reg_write(A_CTRL, 32'h0000_0001);
    reg_read(A_STAT, rd); check("len0_first_cycle", rd, 32'h0000_0001);
    reg_read(A_STAT, rd); check("len0_done", rd, 32'h0000_0002);
    check("len0_no_valid", 32'(valid_hi), 32'd0);

    // slow responder; writes and restart while busy must be ignored
    delay_cfg = 5;
    prep_copy(32'h5000_0000, 32'h5000_2000, 2);
    repeat (2) @(negedge clk);
    reg_write(A_SRC, 32'hDEAD_0000);
    reg_write(A_LEN, 32'd7);
    reg_write(A_CTRL, 32'h0000_0001);
    wait_idle(500, "slow");
    verify_copy("slow");
    reg_read(A_SRC, rd); check("busy_src_ignored", rd, 32'h5000_0000);
    reg_read(A_LEN, rd); check("busy_len_ignored", rd, 32'd2);

    // abort during the second read of a four-word copy
    delay_cfg = 3;
    prep_copy(32'h6000_0000, 32'h6000_3000, 4);
    n = 0;
    while (!(mem_valid === 1'b1 && mem_wstrb === 4'h0 && mem_addr === 32'h6000_0004) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_second_read_seen", mem_addr, 32'h6000_0004);
    reg_write(A_CTRL, 32'h0000_0002);
    wait_idle(500, "abort");
    check("abort_txn_count", 32'(log_addr.size()), 32'd4);
    writes = 0;
    foreach (log_strb[i]) if (log_strb[i] == 4'hF) writes++;
    check("abort_write_count", 32'(writes), 32'd2);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) check("abort_addr", log_addr[i], exp_addr[i]);
    check("abort_word1", mem_rd(32'h6000_3004), exp_src_data[1]);
    check("abort_word2_untouched", mem_rd(32'h6000_3008), 32'h6000_3008 ^ MEMSEED);
    reg_read(A_STAT, rd); check("abort_status", rd, 32'd0);

    // start and abort in one write: abort wins
    log_addr.delete(); log_data.delete(); log_strb.delete();
    valid_hi = 0;
    reg_write(A_CTRL, 32'h0000_0003);
    repeat (3) @(negedge clk);
    reg_read(A_STAT, rd); check("start_abort_status", rd, 32'd0);
    check("start_abort_no_bus", 32'(valid_hi), 32'd0);

    // address wrap past the top of the space
    rand_delay = 1'b1;
    prep_copy(32'hFFFF_FFFC, 32'h0000_0100, 2);
    wait_idle(500, "wrap");
    verify_copy("wrap");
    rd = (log_addr.size() > 2) ? log_addr[2] : 32'hFFFF_FFFF;
    check("wrap_second_read_addr", rd, 32'h0000_0000);

    // randomized copies
    for (int k = 0; k < 4; k++) begin
      s   = 32'h1000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      d   = 32'h2000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      len = int'($urandom_range(1, 6));
      prep_copy(s, d, len);
      wait_idle(1000, "rand");
      verify_copy("rand");
    end

    check("bus_held_stable", 32'(stab_viol), 32'd0);
    check("valid_gap_after_ready", 32'(gap_viol), 32'd0);
    check("idle_wdata_wstrb_zero", 32'(idle_viol), 32'd0);

    // responder never ready
    rand_delay = 1'b0; delay_cfg = -1; valid_hi = 0;
    prep_copy(32'h7000_0000, 32'h7000_1000, 1);
    repeat (40) @(negedge clk);
`ifdef DMA_TIMEOUT_EN
    check("timeout_valid_cycles", 32'(valid_hi), 32'd16);
    reg_read(A_STAT, rd); check("timeout_status", rd, 32'h0000_0004);
`else
    check("no_timeout_valid_held", {31'd0, mem_valid}, 32'd1);
    reg_read(A_STAT, rd); check("no_timeout_busy", rd, 32'h0000_0001);
`endif

    // asynchronous reset mid-transfer
    #2 reset_n = 1'b0;
    #1 check("async_rst_valid", {31'd0, mem_valid}, 32'd0);
    check("async_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    cs = 1'b1; address = A_STAT;
    #1 check("async_rst_status", read_data, 32'd0);
    cs = 1'b0; address = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reg_read(A_STAT, rd); check("post_rst_status", rd, 32'd0);
    reg_read(A_SRC, rd);  check("post_rst_src", rd, 32'd0);
    reg_read(A_LEN, rd);  check("post_rst_len", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
